// File: rtl/ifetch.sv
// Instruction fetch unit: one outstanding memory read feeding a 2-entry {addr,data} queue.
// A flush discards the queue and any in-flight read still owed by memory.
module ifetch (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] pc_addr,
  output logic        PCinc,
  input  logic        flush,
  output logic        mem_req,
  output logic [15:0] mem_addr,
  input  logic        mem_ack,
  input  logic [15:0] mem_data,
  output logic        ir_valid,
  output logic [15:0] ir,
  output logic [15:0] ir_addr,
  input  logic        ir_take
);

  typedef enum logic [1:0] {StIdle, StReq, StDrop} state_e;

  state_e      state_q;
  logic        mem_req_q;
  logic [15:0] mem_addr_q;

  logic [1:0]  count_q, count_d;
  logic [15:0] addr_q [2];
  logic [15:0] addr_d [2];
  logic [15:0] data_q [2];
  logic [15:0] data_d [2];

  logic        wr;
  logic        take;
  logic        wr_slot;

  assign PCinc    = (state_q == StReq) && mem_ack && !flush;
  assign wr       = PCinc;
  assign take     = ir_take && (count_q != 2'd0);
  // Tail index after an optional pop from the head.
  assign wr_slot  = take ? count_q[1] : count_q[0];

  assign mem_req  = mem_req_q;
  assign mem_addr = mem_addr_q;
  assign ir_valid = (count_q != 2'd0);
  assign ir       = data_q[0];
  assign ir_addr  = addr_q[0];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= StIdle;
      mem_req_q  <= 1'b0;
      mem_addr_q <= 16'h0000;
    end else begin
      unique case (state_q)
        StIdle: begin
          if ((count_q < 2'd2) && !flush) begin
            state_q    <= StReq;
            mem_req_q  <= 1'b1;
            mem_addr_q <= pc_addr;
          end
        end
        StReq: begin
          if (mem_ack) begin
            state_q   <= StIdle;
            mem_req_q <= 1'b0;
          end else if (flush) begin
            state_q <= StDrop;
          end
        end
        StDrop: begin
          // The bus cannot be withdrawn, so wait out the stale read.
          if (mem_ack) begin
            state_q   <= StIdle;
            mem_req_q <= 1'b0;
          end
        end
        default: begin
          state_q   <= StIdle;
          mem_req_q <= 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    count_d = count_q;
    addr_d  = addr_q;
    data_d  = data_q;
    if (flush) begin
      count_d = 2'd0;
    end else begin
      if (take) begin
        addr_d[0] = addr_q[1];
        data_d[0] = data_q[1];
      end
      if (wr) begin
        addr_d[wr_slot] = mem_addr_q;
        data_d[wr_slot] = mem_data;
      end
      count_d = count_q + {1'b0, wr} - {1'b0, take};
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_q <= 2'd0;
      addr_q  <= '{default: 16'h0000};
      data_q  <= '{default: 16'h0000};
    end else begin
      count_q <= count_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
    end
  end

endmodule

// File: tb/tb_ifetch.sv
// Bench for ifetch: directed scenarios against a queue-based reference model checked every cycle.
module tb_ifetch;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] pc_addr = 16'h0000;
  logic        PCinc;
  logic        flush = 1'b0;
  logic        mem_req;
  logic [15:0] mem_addr;
  logic        mem_ack = 1'b0;
  logic [15:0] mem_data = 16'h0000;
  logic        ir_valid;
  logic [15:0] ir;
  logic [15:0] ir_addr;
  logic        ir_take = 1'b0;

  ifetch dut (
    .clk      (clk),
    .rst      (rst),
    .pc_addr  (pc_addr),
    .PCinc    (PCinc),
    .flush    (flush),
    .mem_req  (mem_req),
    .mem_addr (mem_addr),
    .mem_ack  (mem_ack),
    .mem_data (mem_data),
    .ir_valid (ir_valid),
    .ir       (ir),
    .ir_addr  (ir_addr),
    .ir_take  (ir_take)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int wait_n = 0;
  int ack_cnt = 0;
  int pc_pulses = 0;
  logic        load_en = 1'b0;
  logic [15:0] load_val = 16'h0000;
  logic [15:0] memw [0:255];

  // Reference model: fetched words in order, plus the one outstanding read.
  typedef struct packed {logic [15:0] a; logic [15:0] d;} ent_t;
  ent_t        q[$];
  bit          m_busy = 1'b0;
  bit          m_drop = 1'b0;
  logic [15:0] m_addr = 16'h0000;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive_ack();
    if (mem_req === 1'b1) begin
      if (ack_cnt >= wait_n) begin
        mem_ack  = 1'b1;
        mem_data = memw[mem_addr[7:0]];
        ack_cnt  = 0;
      end else begin
        mem_ack  = 1'b0;
        mem_data = 16'hDEAD;
        ack_cnt++;
      end
    end else begin
      mem_ack  = 1'b0;
      mem_data = 16'hDEAD;
      ack_cnt  = 0;
    end
  endtask

  // One clock: acts as the program counter and the memory, then clears one-shot inputs.
  task automatic step();
    logic p;
    @(negedge clk);
    p = PCinc;
    @(posedge clk);
    #1;
    if (load_en) pc_addr = load_val;
    else if (p === 1'b1) pc_addr = pc_addr + 16'h0001;
    if (p === 1'b1) pc_pulses++;
    load_en = 1'b0;
    flush   = 1'b0;
    ir_take = 1'b0;
    drive_ack();
  endtask

  task automatic do_reset(input logic [15:0] pc0);
    rst       = 1'b0;
    flush     = 1'b0;
    ir_take   = 1'b0;
    load_en   = 1'b0;
    mem_ack   = 1'b0;
    pc_addr   = pc0;
    pc_pulses = 0;
    ack_cnt   = 0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    drive_ack();
  endtask

  initial begin
    forever begin
      @(posedge clk or negedge rst);
      if (!rst) begin
        q.delete();
        m_busy = 1'b0;
        m_drop = 1'b0;
        m_addr = 16'h0000;
      end else begin
        int n;
        bit acc;
        n   = q.size();
        acc = m_busy && !m_drop && mem_ack && !flush;
        if (flush) begin
          q.delete();
        end else begin
          if (ir_take && n > 0) void'(q.pop_front());
          if (acc) q.push_back({m_addr, mem_data});
        end
        if (!m_busy) begin
          if (n < 2 && !flush) begin
            m_busy = 1'b1;
            m_drop = 1'b0;
            m_addr = pc_addr;
          end
        end else if (mem_ack) begin
          m_busy = 1'b0;
          m_drop = 1'b0;
        end else if (flush) begin
          m_drop = 1'b1;
        end
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (rst === 1'b1) begin
        chk("mdl_mem_req", {31'd0, mem_req}, {31'd0, m_busy});
        if (m_busy) chk("mdl_mem_addr", {16'd0, mem_addr}, {16'd0, m_addr});
        chk("mdl_pcinc", {31'd0, PCinc}, {31'd0, m_busy && !m_drop && mem_ack && !flush});
        chk("mdl_ir_valid", {31'd0, ir_valid}, {31'd0, q.size() != 0});
        if (q.size() != 0) begin
          chk("mdl_ir", {16'd0, ir}, {16'd0, q[0].d});
          chk("mdl_ir_addr", {16'd0, ir_addr}, {16'd0, q[0].a});
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 256; i++) memw[i] = 16'(i) ^ 16'h5A00;

    // Asynchronous reset before any clock edge.
    #2 rst = 1'b0;
    #1;
    chk("rst_mem_req", {31'd0, mem_req}, 32'd0);
    chk("rst_mem_addr", {16'd0, mem_addr}, 32'd0);
    chk("rst_ir_valid", {31'd0, ir_valid}, 32'd0);
    chk("rst_ir", {16'd0, ir}, 32'd0);
    chk("rst_ir_addr", {16'd0, ir_addr}, 32'd0);
    chk("rst_pcinc", {31'd0, PCinc}, 32'd0);

    // First fetch with two memory wait cycles.
    memw[0] = 16'h1234;
    wait_n  = 2;
    do_reset(16'h0000);
    for (int i = 0; i < 20 && pc_pulses == 0; i++) step();
    chk("t1_pulses", pc_pulses, 32'd1);
    chk("t1_ir_valid", {31'd0, ir_valid}, 32'd1);
    chk("t1_ir", {16'd0, ir}, 32'h1234);
    chk("t1_ir_addr", {16'd0, ir_addr}, 32'h0000);
    step();
    chk("t1_single_pulse", pc_pulses, 32'd1);

    // Zero-wait memory fills the queue and then stops requesting.
    wait_n = 0;
    do_reset(16'h0000);
    repeat (12) step();
    chk("t2_pulses", pc_pulses, 32'd2);
    chk("t2_pc", {16'd0, pc_addr}, 32'h0002);
    chk("t2_no_req_full", {31'd0, mem_req}, 32'd0);
    chk("t2_head_addr", {16'd0, ir_addr}, 32'h0000);
    chk("t2_head", {16'd0, ir}, 32'h1234);
    ir_take = 1'b1;
    step();
    chk("t2_pop_addr", {16'd0, ir_addr}, 32'h0001);
    chk("t2_pop_data", {16'd0, ir}, 32'h5A01);
    chk("t2_req_wait", {31'd0, mem_req}, 32'd0);
    step();
    chk("t2_new_req", {31'd0, mem_req}, 32'd1);
    chk("t2_new_addr", {16'd0, mem_addr}, 32'h0002);

    // Flush while a read is outstanding; the stale word must be dropped.
    memw[0] = 16'hBEEF;
    wait_n  = 3;
    do_reset(16'h0000);
    step();
    chk("t3_req", {31'd0, mem_req}, 32'd1);
    flush    = 1'b1;
    load_en  = 1'b1;
    load_val = 16'h0040;
    step();
    chk("t3_drop_req_held", {31'd0, mem_req}, 32'd1);
    chk("t3_drop_addr_held", {16'd0, mem_addr}, 32'h0000);
    chk("t3_pc_loaded", {16'd0, pc_addr}, 32'h0040);
    for (int i = 0; i < 20 && mem_req === 1'b1; i++) step();
    chk("t3_req_done", {31'd0, mem_req}, 32'd0);
    chk("t3_no_pulse", pc_pulses, 32'd0);
    chk("t3_empty", {31'd0, ir_valid}, 32'd0);
    step();
    chk("t3_next_req", {31'd0, mem_req}, 32'd1);
    chk("t3_next_addr", {16'd0, mem_addr}, 32'h0040);

    // Flush coinciding with the acknowledge.
    wait_n = 2;
    do_reset(16'h0000);
    step();
    for (int i = 0; i < 10 && mem_ack !== 1'b1; i++) step();
    chk("t4_ack_seen", {31'd0, mem_ack}, 32'd1);
    flush = 1'b1;
    step();
    chk("t4_no_pulse", pc_pulses, 32'd0);
    chk("t4_empty", {31'd0, ir_valid}, 32'd0);
    chk("t4_idle", {31'd0, mem_req}, 32'd0);
    step();
    chk("t4_req_again", {31'd0, mem_req}, 32'd1);
    chk("t4_req_addr", {16'd0, mem_addr}, 32'h0000);

    // Simultaneous take and write at count=1; take at count=0.
    wait_n = 0;
    do_reset(16'h0000);
    for (int i = 0; i < 10 && pc_pulses == 0; i++) step();
    step();
    ir_take = 1'b1;
    step();
    chk("t5_valid", {31'd0, ir_valid}, 32'd1);
    chk("t5_head_addr", {16'd0, ir_addr}, 32'h0001);
    chk("t5_head", {16'd0, ir}, 32'h5A01);
    chk("t5_pulses", pc_pulses, 32'd2);
    ir_take = 1'b1;
    step();
    chk("t5_drained", {31'd0, ir_valid}, 32'd0);
    chk("t5_req2", {16'd0, mem_addr}, 32'h0002);
    ir_take = 1'b1;
    step();
    chk("t5_take_empty_valid", {31'd0, ir_valid}, 32'd1);
    chk("t5_take_empty_addr", {16'd0, ir_addr}, 32'h0002);
    chk("t5_take_empty_data", {16'd0, ir}, 32'h5A02);

    // Reset asserted mid-request with a non-empty queue.
    wait_n = 0;
    do_reset(16'h0000);
    for (int i = 0; i < 10 && pc_pulses == 0; i++) step();
    wait_n = 20;
    step();
    chk("t6_busy", {31'd0, mem_req}, 32'd1);
    chk("t6_full_ish", {31'd0, ir_valid}, 32'd1);
    #2;
    rst     = 1'b0;
    pc_addr = 16'h0100;
    #1;
    chk("t6_async_req", {31'd0, mem_req}, 32'd0);
    chk("t6_async_valid", {31'd0, ir_valid}, 32'd0);
    chk("t6_async_addr", {16'd0, mem_addr}, 32'd0);
    chk("t6_async_ir", {16'd0, ir}, 32'd0);
    chk("t6_async_pcinc", {31'd0, PCinc}, 32'd0);
    do_reset(16'h0100);
    step();
    chk("t6_restart_req", {31'd0, mem_req}, 32'd1);
    chk("t6_restart_addr", {16'd0, mem_addr}, 32'h0100);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
